// File: rtl/rgb565_gauss3x3.sv
// rtl/rgb565_gauss3x3.sv - streaming 3x3 Gaussian low-pass filter for RGB565 video
//
// Kernel [1 2 1; 2 4 2; 1 2 1]/16 per colour channel, fixed 3-cycle latency.
// The output pixel emitted alongside input (row, col) is centred on input
// (row-1, col-1); border pixels (row<2 or col<2) and pixels beyond H_ACTIVE
// pass through unfiltered with the same latency.
//
// Optional build macro: GAUSS_ROUND_EN
//   defined   : result = (sum+8)>>4, saturated to the channel maximum
//   undefined : result = sum>>4, truncated
//
// Ports:
//   clk       pixel clock, rising edge
//   rst_n     asynchronous active-low reset
//   in_hs     horizontal sync, delayed only
//   in_vs     vertical sync, clears the line counter
//   in_de     data enable
//   in_data   RGB565 input pixel
//   out_hs    in_hs delayed 3 cycles
//   out_vs    in_vs delayed 3 cycles
//   out_de    in_de delayed 3 cycles
//   out_data  filtered RGB565 pixel, valid when out_de=1

module rgb565_gauss3x3 #(
    parameter int H_ACTIVE  = 800,
    parameter int RGB_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_hs,
    input  logic                 in_vs,
    input  logic                 in_de,
    input  logic [RGB_WIDTH-1:0] in_data,
    output logic                 out_hs,
    output logic                 out_vs,
    output logic                 out_de,
    output logic [RGB_WIDTH-1:0] out_data
);

    localparam int COL_W  = $clog2(H_ACTIVE + 1);
    localparam int ADDR_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

`ifdef GAUSS_ROUND_EN
    localparam logic [3:0] RND = 4'd8;
`else
    localparam logic [3:0] RND = 4'd0;
`endif

    // ------------------------------------------------------------------
    // Arithmetic helpers: row sums weight the middle tap by 2; totals
    // weight the middle row by 2.
    // ------------------------------------------------------------------
    function automatic logic [6:0] rs5(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [7:0] rs6(input logic [5:0] a, input logic [5:0] b,
                                       input logic [5:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    function automatic logic [8:0] tot5(input logic [6:0] t, input logic [6:0] m,
                                        input logic [6:0] b);
        return {2'b00, t} + {1'b0, m, 1'b0} + {2'b00, b};
    endfunction

    function automatic logic [9:0] tot6(input logic [7:0] t, input logic [7:0] m,
                                        input logic [7:0] b);
        return {2'b00, t} + {1'b0, m, 1'b0} + {2'b00, b};
    endfunction

    // Saturation never fires when RND is zero, since the sums cannot exceed 16x max.
    function automatic logic [4:0] q5(input logic [8:0] s);
        logic [9:0] r;
        r = {1'b0, s} + {6'd0, RND};
        return (r[9:4] > 6'd31) ? 5'd31 : r[8:4];
    endfunction

    function automatic logic [5:0] q6(input logic [9:0] s);
        logic [10:0] r;
        r = {1'b0, s} + {7'd0, RND};
        return (r[10:4] > 7'd63) ? 6'd63 : r[9:4];
    endfunction

    // ------------------------------------------------------------------
    // Column / line counters
    // ------------------------------------------------------------------
    logic [COL_W-1:0]  col;
    logic [1:0]        row;
    logic              de_d;
    logic              col_ok;
    logic [ADDR_W-1:0] addr;

    assign col_ok = (col < COL_W'(H_ACTIVE));
    assign addr   = col_ok ? col[ADDR_W-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col  <= '0;
            row  <= '0;
            de_d <= 1'b0;
        end else begin
            de_d <= in_de;
            if (!in_de)
                col <= '0;
            else if (col_ok)
                col <= col + 1'b1;  // parks at H_ACTIVE: everything beyond bypasses
            if (in_vs)
                row <= '0;
            else if (de_d && !in_de && row != 2'd2)
                row <= row + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: combinational read, write at the same address on the
    // clock edge, so the read sees the previous line (read-before-write).
    // ------------------------------------------------------------------
    logic [15:0] lb1 [0:H_ACTIVE-1];
    logic [15:0] lb2 [0:H_ACTIVE-1];
    logic [15:0] lb1_rd;
    logic [15:0] lb2_rd;

    assign lb1_rd = lb1[addr];
    assign lb2_rd = lb2[addr];

    always_ff @(posedge clk) begin
        if (in_de && col_ok) begin
            lb1[addr] <= in_data;
            lb2[addr] <= lb1_rd;
        end
    end

    logic bypass_in;
    assign bypass_in = !in_de || !row[1] || (col <= COL_W'(1)) || !col_ok;

    // ------------------------------------------------------------------
    // Stage 1: window taps. win[r][t]: r = 0 top, 1 middle, 2 bottom;
    // t = 0 col, 1 col-1, 2 col-2. Taps only move on stored pixels.
    // ------------------------------------------------------------------
    logic [15:0] win [3][3];
    logic [15:0] s1_pix;
    logic        s1_byp;
    logic [2:0]  s1_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++)
                for (int t = 0; t < 3; t++)
                    win[r][t] <= '0;
            s1_pix  <= '0;
            s1_byp  <= 1'b0;
            s1_sync <= '0;
        end else begin
            if (in_de && col_ok) begin
                win[0][0] <= lb2_rd;
                win[1][0] <= lb1_rd;
                win[2][0] <= in_data;
                for (int r = 0; r < 3; r++) begin
                    win[r][1] <= win[r][0];
                    win[r][2] <= win[r][1];
                end
            end
            s1_pix  <= in_data;
            s1_byp  <= bypass_in;
            s1_sync <= {in_hs, in_vs, in_de};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: weighted row sums per channel (index 0 top .. 2 bottom)
    // ------------------------------------------------------------------
    logic [6:0]  s2_r [3];
    logic [7:0]  s2_g [3];
    logic [6:0]  s2_b [3];
    logic [15:0] s2_pix;
    logic        s2_byp;
    logic [2:0]  s2_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                s2_r[r] <= '0;
                s2_g[r] <= '0;
                s2_b[r] <= '0;
            end
            s2_pix  <= '0;
            s2_byp  <= 1'b0;
            s2_sync <= '0;
        end else begin
            for (int r = 0; r < 3; r++) begin
                s2_r[r] <= rs5(win[r][0][15:11], win[r][1][15:11], win[r][2][15:11]);
                s2_g[r] <= rs6(win[r][0][10:5],  win[r][1][10:5],  win[r][2][10:5]);
                s2_b[r] <= rs5(win[r][0][4:0],   win[r][1][4:0],   win[r][2][4:0]);
            end
            s2_pix  <= s1_pix;
            s2_byp  <= s1_byp;
            s2_sync <= s1_sync;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: total, scale, repack
    // ------------------------------------------------------------------
    logic [4:0] q_r;
    logic [5:0] q_g;
    logic [4:0] q_b;

    assign q_r = q5(tot5(s2_r[0], s2_r[1], s2_r[2]));
    assign q_g = q6(tot6(s2_g[0], s2_g[1], s2_g[2]));
    assign q_b = q5(tot5(s2_b[0], s2_b[1], s2_b[2]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_hs   <= 1'b0;
            out_vs   <= 1'b0;
            out_de   <= 1'b0;
            out_data <= '0;
        end else begin
            {out_hs, out_vs, out_de} <= s2_sync;
            out_data <= s2_byp ? s2_pix : {q_r, q_g, q_b};
        end
    end

endmodule

// File: tb/tb_rgb565_gauss3x3.sv
// tb/tb_rgb565_gauss3x3.sv - self-checking bench for rgb565_gauss3x3

module tb_rgb565_gauss3x3;

    localparam int H = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_hs = 1'b0;
    logic        in_vs = 1'b0;
    logic        in_de = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_hs;
    logic        out_vs;
    logic        out_de;
    logic [15:0] out_data;

    rgb565_gauss3x3 #(.H_ACTIVE(H), .RGB_WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_hs    (in_hs),
        .in_vs    (in_vs),
        .in_de    (in_de),
        .in_data  (in_data),
        .out_hs   (out_hs),
        .out_vs   (out_vs),
        .out_de   (out_de),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: whole input image by line/column, Gaussian over
    // the 3x3 neighbourhood, then a 3-entry delay of expected outputs.
    // ------------------------------------------------------------------
    logic [15:0] img [0:15][0:H-1];
    int          mrow = 0;
    int          mcol = 0;
    logic        mprev = 1'b0;
    logic [18:0] hist [0:2] = '{default: '0};

    function automatic logic [15:0] gauss(input logic [8:0][15:0] w);
        int sr, sg, sb, wt, qr, qg, qb;
        sr = 0; sg = 0; sb = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                wt = ((i == 1) ? 2 : 1) * ((j == 1) ? 2 : 1);
                sr += wt * int'(w[i*3+j][15:11]);
                sg += wt * int'(w[i*3+j][10:5]);
                sb += wt * int'(w[i*3+j][4:0]);
            end
`ifdef GAUSS_ROUND_EN
        qr = (sr + 8) / 16; if (qr > 31) qr = 31;
        qg = (sg + 8) / 16; if (qg > 63) qg = 63;
        qb = (sb + 8) / 16; if (qb > 31) qb = 31;
`else
        qr = sr / 16;
        qg = sg / 16;
        qb = sb / 16;
`endif
        return {5'(qr), 6'(qg), 5'(qb)};
    endfunction

    function automatic logic [15:0] model_pix();
        logic [8:0][15:0] w;
        if (!in_de || mrow < 2 || mcol < 2 || mcol >= H)
            return in_data;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i*3+j] = (i == 2 && j == 2) ? in_data : img[mrow-2+i][mcol-2+j];
        return gauss(w);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mrow  <= 0;
            mcol  <= 0;
            mprev <= 1'b0;
            hist[0] <= '0;
            hist[1] <= '0;
            hist[2] <= '0;
        end else begin
            hist[0] <= {in_hs, in_vs, in_de, model_pix()};
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            if (in_de && mcol < H)
                img[mrow][mcol] <= in_data;
            mcol  <= in_de ? ((mcol < 31) ? mcol + 1 : mcol) : 0;
            mprev <= in_de;
            if (in_vs)
                mrow <= 0;
            else if (mprev && !in_de && mrow < 15)
                mrow <= mrow + 1;
        end
    end

    // ------------------------------------------------------------------
    // Compare every cycle, and capture the output image by out line/col.
    // ------------------------------------------------------------------
    logic [15:0] out_img [0:15][0:15];
    logic [15:0] ref_img [0:15][0:15];

    initial begin
        int oline, ocol;
        logic oprev, ovs_prev;
        oline = 0; ocol = 0; oprev = 1'b0; ovs_prev = 1'b0;
        forever begin
            @(negedge clk);
            check("sync hs/vs/de", {29'd0, out_hs, out_vs, out_de}, {29'd0, hist[2][18:16]});
            if (hist[2][16])
                check($sformatf("data line %0d col %0d", oline, ocol), {16'd0, out_data},
                      {16'd0, hist[2][15:0]});
            if (out_vs) begin
                if (!ovs_prev)
                    for (int r = 0; r < 16; r++)
                        for (int c = 0; c < 16; c++)
                            out_img[r][c] = 16'hDEAD;
                oline = 0;
                ocol  = 0;
            end else if (out_de) begin
                if (oline < 16 && ocol < 16)
                    out_img[oline][ocol] = out_data;
                ocol++;
            end else if (oprev) begin
                oline++;
                ocol = 0;
            end
            oprev    = out_de;
            ovs_prev = out_vs;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    function automatic logic [15:0] pix(input int kind, input int r, input int c);
        case (kind)
            0: return 16'hFFFF;
            1: return (r == 3 && c == 3) ? 16'h8000 : 16'h0000;
            2: return 16'(c + r * 8);
            3: return 16'h07E0;
            4: return (r == 3 && c == 3) ? 16'h0800 : 16'h0000;
            5: return (c == 3 && r >= 2 && r <= 4) ? 16'h0800 : 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic drive(input logic hs, input logic vs, input logic de, input logic [15:0] d);
        @(posedge clk);
        #1;
        in_hs = hs; in_vs = vs; in_de = de; in_data = d;
    endtask

    task automatic run_frame(input int kind, input int nlines, input int npix, input int gap);
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int r = 0; r < nlines; r++) begin
            for (int g = 0; g < gap; g++)
                drive(g == 0, 1'b0, 1'b0, 16'h0);
            for (int c = 0; c < npix; c++)
                drive(1'b0, 1'b0, 1'b1, pix(kind, r, c));
        end
        repeat (6) drive(1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic lit(input int r, input int c, input logic [15:0] want);
        check($sformatf("lit[%0d][%0d]", r, c), {16'd0, out_img[r][c]}, {16'd0, want});
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {13'd0, out_hs, out_vs, out_de, out_data}, 32'd0);
        rst_n = 1'b1;

        // constant white
        run_frame(0, 4, 8, 2);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                lit(r, c, 16'hFFFF);

        // red impulse at (3,3)
        run_frame(1, 8, 8, 2);
        lit(4, 4, 16'h2000);
        lit(4, 3, 16'h1000);
        lit(4, 5, 16'h1000);
        lit(3, 4, 16'h1000);
        lit(5, 4, 16'h1000);
        lit(3, 3, 16'h0800);
        lit(3, 5, 16'h0800);
        lit(5, 3, 16'h0800);
        lit(5, 5, 16'h0800);
        lit(2, 2, 16'h0000);
        lit(6, 6, 16'h0000);
        lit(4, 6, 16'h0000);
        lit(7, 7, 16'h0000);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                ref_img[r][c] = out_img[r][c];

        // same impulse with long de-low gaps between lines
        run_frame(1, 8, 8, 6);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                check($sformatf("gappy[%0d][%0d]", r, c), {16'd0, out_img[r][c]},
                      {16'd0, ref_img[r][c]});

        // ramp with two pixels past H_ACTIVE per line
        run_frame(2, 6, 10, 2);
        for (int r = 0; r < 6; r++)
            for (int c = 0; c < 10; c++)
                if (r < 2 || c < 2 || c >= H)
                    lit(r, c, 16'(c + r * 8));

        // random content, model only
        run_frame(6, 6, 8, 3);

        // rounding cases
        run_frame(4, 6, 8, 2);
        lit(4, 4, 16'h0000);
        run_frame(5, 6, 8, 2);
`ifdef GAUSS_ROUND_EN
        lit(4, 4, 16'h0800);
`else
        lit(4, 4, 16'h0000);
`endif

        // reset mid-line
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        repeat (2) drive(1'b0, 1'b0, 1'b0, 16'h0);
        repeat (5) drive(1'b0, 1'b0, 1'b1, 16'h07E0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        in_de = 1'b0; in_data = '0;
        #1;
        check("async reset", {13'd0, out_hs, out_vs, out_de, out_data}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(3, 4, 8, 2);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 8; c++)
                lit(r, c, 16'h07E0);

        repeat (4) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
